// File: rtl/lsu_mem_responder.sv
// LSU load/store memory responder: one request in flight, round-robin tie
// arbitration, fixed-wait access to a single-port synchronous SRAM.
module lsu_mem_responder #(
    parameter int LATENCY = 2,
    parameter int INDEX_W = 19,
    parameter int DATA_W  = 64
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               opload_index_valid,
    input  logic [INDEX_W-1:0] opload_index,
    output logic               opload_index_ready,
    output logic [DATA_W-1:0]  opload_read_data,
    output logic               opload_operation_done,
    input  logic               opstore_index_valid,
    input  logic [INDEX_W-1:0] opstore_index,
    input  logic [DATA_W-1:0]  opstore_write_data,
    input  logic [DATA_W-1:0]  opstore_write_mask,
    output logic               opstore_index_ready,
    output logic               opstore_operation_done,
    output logic               sram_en,
    output logic               sram_we,
    output logic [INDEX_W-1:0] sram_addr,
    output logic [DATA_W-1:0]  sram_wdata,
    output logic [DATA_W-1:0]  sram_wmask,
    input  logic [DATA_W-1:0]  sram_rdata
);
    typedef enum logic [1:0] {IDLE, BUSY, ACCESS, RESP} state_e;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               is_store_q, is_store_d;
    logic               last_st_q, last_st_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  wmask_q, wmask_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               ld_done_q, ld_done_d;
    logic               st_done_q, st_done_d;
    logic               ld_grant, st_grant;

    // On a tie the channel that did not win last time gets the grant.
    always_comb begin
        ld_grant = 1'b0;
        st_grant = 1'b0;
        if (reset_n && state_q == IDLE) begin
            if (opload_index_valid && opstore_index_valid) begin
                ld_grant = last_st_q;
                st_grant = !last_st_q;
            end else begin
                ld_grant = opload_index_valid;
                st_grant = opstore_index_valid;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        is_store_d = is_store_q;
        last_st_d  = last_st_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        rdata_d    = rdata_q;
        ld_done_d  = 1'b0;
        st_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_grant || st_grant) begin
                    state_d    = BUSY;
                    cnt_d      = CNT_INIT;
                    is_store_d = st_grant;
                    last_st_d  = st_grant;
                    idx_d      = st_grant ? opstore_index : opload_index;
                    if (st_grant) begin
                        wdata_d = opstore_write_data;
                        wmask_d = opstore_write_mask;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) state_d = ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                state_d   = IDLE;
                ld_done_d = !is_store_q;
                st_done_d = is_store_q;
                if (!is_store_q) rdata_d = sram_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            is_store_q <= 1'b0;
            last_st_q  <= 1'b1;
            idx_q      <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            rdata_q    <= '0;
            ld_done_q  <= 1'b0;
            st_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            is_store_q <= is_store_d;
            last_st_q  <= last_st_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            rdata_q    <= rdata_d;
            ld_done_q  <= ld_done_d;
            st_done_q  <= st_done_d;
        end
    end

    // SRAM bus is driven only during ACCESS and reads as zero otherwise.
    assign sram_en    = (state_q == ACCESS);
    assign sram_we    = sram_en && is_store_q;
    assign sram_addr  = sram_en ? idx_q   : '0;
    assign sram_wdata = sram_en ? wdata_q : '0;
    assign sram_wmask = sram_en ? wmask_q : '0;

    assign opload_index_ready     = ld_grant;
    assign opstore_index_ready    = st_grant;
    assign opload_read_data       = rdata_q;
    assign opload_operation_done  = ld_done_q;
    assign opstore_operation_done = st_done_q;
endmodule

// File: tb/tb_lsu_mem_responder.sv
// Bench for lsu_mem_responder: directed vectors, arbitration and reset corner
// cases, latency-variant builds and a randomized transaction-level model.
module tb_lsu_mem_responder;
    localparam int IW = 19;
    localparam int DW = 64;
    localparam int LAT = 2;
    localparam logic [DW-1:0] XK = 64'hC0FFEE00_12345678;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          lv, lr, ldone, sv, sr, sdone, en, we;
    logic [IW-1:0] li, si, addr;
    logic [DW-1:0] lrd, swd, swm, wd, wm, rd;

    lsu_mem_responder #(.LATENCY(LAT), .INDEX_W(IW), .DATA_W(DW)) dut (
        .clock(clk), .reset_n(rst_n),
        .opload_index_valid(lv), .opload_index(li), .opload_index_ready(lr),
        .opload_read_data(lrd), .opload_operation_done(ldone),
        .opstore_index_valid(sv), .opstore_index(si), .opstore_write_data(swd),
        .opstore_write_mask(swm), .opstore_index_ready(sr), .opstore_operation_done(sdone),
        .sram_en(en), .sram_we(we), .sram_addr(addr), .sram_wdata(wd),
        .sram_wmask(wm), .sram_rdata(rd)
    );

    // Latency-variant builds: index 0 is LATENCY=1, index 1 is LATENCY=15; loads only.
    logic [1:0]          xlv, xlr, xldone, xsr, xsdone, xen, xwe;
    logic [1:0][IW-1:0]  xli, xaddr;
    logic [1:0][DW-1:0]  xlrd, xwd, xwm, xrd;

    lsu_mem_responder #(.LATENCY(1), .INDEX_W(IW), .DATA_W(DW)) dut_l1 (
        .clock(clk), .reset_n(rst_n),
        .opload_index_valid(xlv[0]), .opload_index(xli[0]), .opload_index_ready(xlr[0]),
        .opload_read_data(xlrd[0]), .opload_operation_done(xldone[0]),
        .opstore_index_valid(1'b0), .opstore_index('0), .opstore_write_data('0),
        .opstore_write_mask('0), .opstore_index_ready(xsr[0]), .opstore_operation_done(xsdone[0]),
        .sram_en(xen[0]), .sram_we(xwe[0]), .sram_addr(xaddr[0]), .sram_wdata(xwd[0]),
        .sram_wmask(xwm[0]), .sram_rdata(xrd[0])
    );

    lsu_mem_responder #(.LATENCY(15), .INDEX_W(IW), .DATA_W(DW)) dut_l15 (
        .clock(clk), .reset_n(rst_n),
        .opload_index_valid(xlv[1]), .opload_index(xli[1]), .opload_index_ready(xlr[1]),
        .opload_read_data(xlrd[1]), .opload_operation_done(xldone[1]),
        .opstore_index_valid(1'b0), .opstore_index('0), .opstore_write_data('0),
        .opstore_write_mask('0), .opstore_index_ready(xsr[1]), .opstore_operation_done(xsdone[1]),
        .sram_en(xen[1]), .sram_we(xwe[1]), .sram_addr(xaddr[1]), .sram_wdata(xwd[1]),
        .sram_wmask(xwm[1]), .sram_rdata(xrd[1])
    );

    // Synchronous SRAM model for the main instance; fixed pattern for the variants.
    logic [DW-1:0] mem [1024] = '{default: '0};
    int en_cnt = 0;
    int xen_cnt [2] = '{0, 0};

    always @(posedge clk) begin
        if (en) begin
            en_cnt <= en_cnt + 1;
            if (we) mem[addr[9:0]] <= (mem[addr[9:0]] & ~wm) | (wd & wm);
            else    rd <= mem[addr[9:0]];
        end
        for (int i = 0; i < 2; i++) begin
            if (xen[i]) begin
                xen_cnt[i] <= xen_cnt[i] + 1;
                xrd[i]     <= {{(DW-IW){1'b0}}, xaddr[i]} ^ XK;
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        lv = 1'b0; sv = 1'b0; xlv = '0; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issue one request and return cycles from acceptance edge to done (0 on timeout).
    task automatic do_req(input bit st, input logic [IW-1:0] idx,
                          input logic [DW-1:0] d, input logic [DW-1:0] m, output int lat);
        int w = 0;
        lat = 0;
        if (st) begin sv = 1'b1; si = idx; swd = d; swm = m; end
        else    begin lv = 1'b1; li = idx; end
        #1;
        while (!(st ? sr : lr) && w < 50) begin @(negedge clk); #1; w++; end
        if (w >= 50) begin
            check("accept_timeout", 1'b1, 1'b0);
            lv = 1'b0; sv = 1'b0;
            return;
        end
        @(negedge clk);
        lv = 1'b0; sv = 1'b0;
        lat = 1;
        while (!(st ? sdone : ldone) && lat < 40) begin @(negedge clk); lat++; end
    endtask

    typedef struct {
        bit            st;
        logic [IW-1:0] idx;
        logic [DW-1:0] d;
        logic [DW-1:0] m;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t          vecs [8];
    int            lat, e0, both, ng, nd;
    int            gk [4];
    int            gc [4];
    int            dn [4];
    logic [DW-1:0] shadow [16];
    logic [DW-1:0] exp_rd, pend_data, pend_wd, pend_wm;
    logic [IW-1:0] pend_idx;
    bit            pend_ld, last_st, sdone_seen;
    longint        cyc, acc_at, done_at, free_at;
    logic          idle, elr, esr, eld, esd, een, ewe;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 19'h00010, 64'h1122334455667788, '1, 64'h0};
        vecs[1] = '{1'b0, 19'h00010, 64'h0, 64'h0, 64'h1122334455667788};
        vecs[2] = '{1'b1, 19'h00010, '1, 64'h00000000FFFFFFFF, 64'h1122334455667788};
        vecs[3] = '{1'b0, 19'h00010, 64'h0, 64'h0, 64'h11223344FFFFFFFF};
        vecs[4] = '{1'b1, 19'h00010, 64'h0, 64'h0, 64'h11223344FFFFFFFF};
        vecs[5] = '{1'b0, 19'h00010, 64'h0, 64'h0, 64'h11223344FFFFFFFF};
        vecs[6] = '{1'b1, 19'h00011, 64'hDEADBEEFCAFEF00D, 64'hF0F0F0F0F0F0F0F0, 64'h11223344FFFFFFFF};
        vecs[7] = '{1'b0, 19'h00011, 64'h0, 64'h0, 64'hD0A0B0E0C0F0F000};

        lv = 1'b0; sv = 1'b0; li = '0; si = '0; swd = '0; swm = '0;
        xlv = '0; xli = '0;

        // Reset: readies stay low even with both valids high, outputs clear.
        rst_n = 1'b0; lv = 1'b1; sv = 1'b1;
        @(negedge clk); #1;
        check("rst_ready", {lr, sr}, 2'b00);
        @(negedge clk);
        check("rst_outputs", {ldone, sdone, en, we, addr, wd, wm, lrd}, '0);
        lv = 1'b0; sv = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("idle_quiet", {lr, sr, ldone, sdone, en, lrd}, '0);
        end

        // Directed vectors: latency, single SRAM strobe, read data and hold on store done.
        for (int i = 0; i < 8; i++) begin
            e0 = en_cnt;
            do_req(vecs[i].st, vecs[i].idx, vecs[i].d, vecs[i].m, lat);
            check($sformatf("vec%0d_latency", i), lat, 5);
            check($sformatf("vec%0d_done_sel", i), {ldone, sdone}, vecs[i].st ? 2'b01 : 2'b10);
            check($sformatf("vec%0d_read_data", i), lrd, vecs[i].exp_rd);
            check($sformatf("vec%0d_sram_en_count", i), en_cnt - e0, 1);
        end

        // Persistent tie from reset: load, store, load, store, five cycles apart.
        do_reset();
        li = 19'h00010; si = 19'h00012; swd = 64'h0123456789ABCDEF; swm = '1;
        lv = 1'b1; sv = 1'b1;
        both = 0; ng = 0; nd = 0;
        for (int k = 0; k < 4; k++) begin gk[k] = 9; gc[k] = -99; dn[k] = 9; end
        for (int c = 0; c < 30 && ng < 4; c++) begin
            #1;
            if (lr && sr) both++;
            if ((ldone || sdone) && nd < 4) begin dn[nd] = sdone ? 1 : 0; nd++; end
            if (lr || sr) begin gk[ng] = sr ? 1 : 0; gc[ng] = c; ng++; end
            @(negedge clk);
        end
        lv = 1'b0; sv = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if ((ldone || sdone) && nd < 4) begin dn[nd] = sdone ? 1 : 0; nd++; end
            @(negedge clk);
        end
        check("tie_both_ready", both, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("tie_grant%0d_channel", k), gk[k], k % 2);
            check($sformatf("tie_done%0d_channel", k), dn[k], k % 2);
        end
        for (int k = 1; k < 4; k++) check($sformatf("tie_spacing%0d", k), gc[k] - gc[k-1], 5);

        // Reset during BUSY of a store: dropped without strobe or done.
        do_reset();
        sv = 1'b1; si = 19'h00010; swd = 64'h0; swm = '1;
        #1;
        check("rbusy_store_ready", sr, 1'b1);
        @(negedge clk);
        sv = 1'b0;
        e0 = en_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sdone_seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            if (sdone) sdone_seen = 1'b1;
        end
        check("rbusy_no_done", sdone_seen, 1'b0);
        check("rbusy_no_strobe", en_cnt - e0, 0);
        do_req(1'b0, 19'h00010, '0, '0, lat);
        check("rbusy_load_latency", lat, 5);
        check("rbusy_load_data", lrd, 64'h11223344FFFFFFFF);

        // LATENCY=1 and LATENCY=15 builds.
        for (int s = 0; s < 2; s++) begin
            int w = 0;
            logic [DW-1:0] xexp;
            e0 = xen_cnt[s];
            xli[s] = 19'h00020 + 19'(s);
            xexp = {{(DW-IW){1'b0}}, xli[s]} ^ XK;
            xlv[s] = 1'b1;
            #1;
            while (!xlr[s] && w < 50) begin @(negedge clk); #1; w++; end
            @(negedge clk);
            xlv[s] = 1'b0;
            lat = 1;
            while (!xldone[s] && lat < 40) begin @(negedge clk); lat++; end
            check($sformatf("xlat%0d_latency", s), lat, s ? 18 : 4);
            check($sformatf("xlat%0d_read_data", s), xlrd[s], xexp);
            check($sformatf("xlat%0d_sram_en_count", s), xen_cnt[s] - e0, 1);
        end
        check("xlat_store_side_quiet", {xsr, xsdone, xwe, |xwd[0], |xwd[1], |xwm[0], |xwm[1]}, '0);

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        cyc = 0; free_at = 0; acc_at = -1; done_at = -1;
        last_st = 1'b1; pend_ld = 1'b0; exp_rd = '0;
        pend_idx = '0; pend_data = '0; pend_wd = '0; pend_wm = '0;
        for (int n = 0; n < 400; n++) begin
            int msel;
            lv  = 1'($urandom);
            sv  = 1'($urandom);
            li  = 19'h00100 + 19'($urandom_range(15));
            si  = 19'h00100 + 19'($urandom_range(15));
            swd = {$urandom, $urandom};
            msel = $urandom_range(3);
            swm = (msel == 0) ? '1 : (msel == 1) ? '0 : {$urandom, $urandom};
            #1;
            idle = (cyc >= free_at);
            elr  = idle && lv && (!sv || last_st);
            esr  = idle && sv && (!lv || !last_st);
            eld  = (cyc == done_at) && pend_ld;
            esd  = (cyc == done_at) && !pend_ld;
            een  = (cyc == acc_at);
            ewe  = een && !pend_ld;
            if (eld) exp_rd = pend_data;
            check("rand_cycle", {lr, sr, ldone, sdone, en, we, lrd},
                  {elr, esr, eld, esd, een, ewe, exp_rd});
            if (een) check("rand_sram_addr", addr, pend_idx);
            if (ewe) check("rand_sram_wdata_wmask", {wd, wm}, {pend_wd, pend_wm});
            if (elr || esr) begin
                pend_ld  = elr;
                pend_idx = elr ? li : si;
                last_st  = esr;
                acc_at   = cyc + LAT + 1;
                done_at  = cyc + LAT + 3;
                free_at  = done_at;
                if (elr) begin
                    pend_data = shadow[li[3:0]];
                end else begin
                    pend_wd = swd;
                    pend_wm = swm;
                    shadow[si[3:0]] = (shadow[si[3:0]] & ~swm) | (swd & swm);
                end
            end
            @(negedge clk);
            cyc++;
        end
        lv = 1'b0; sv = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lsu_mem_responder.md
# lsu_mem_responder

Memory-side responder for the backend's LSU load and store channels (opload/opstore). It accepts one request at a time from either channel, arbitrating round-robin on a tie. It issues the access to a single-port synchronous SRAM after a configurable wait, then returns a one-cycle operation-done pulse, plus read data for loads. It sits between the core backend and the L1 D$/memory model.

## Interface
- LATENCY, 2, wait cycles between request acceptance and the SRAM access; legal range 1..15
- INDEX_W, 19, width of the 64-bit-word index
- DATA_W, 64, data and mask width
- clock  in  1  system clock, all state updates on the rising edge
- reset_n  in  1  reset; one clock, synchronous and active-low
- opload_index_valid  in  1  load request valid
- opload_index  in  INDEX_W  load word index
- opload_index_ready  out  1  load request accepted this cycle when high together with valid
- opload_read_data  out  DATA_W  registered load data; holds until the next load completes
- opload_operation_done  out  1  one-cycle pulse, load complete
- opstore_index_valid  in  1  store request valid
- opstore_index  in  INDEX_W  store word index
- opstore_write_data  in  DATA_W  store data
- opstore_write_mask  in  DATA_W  per-bit write enable, 1 = write
- opstore_index_ready  out  1  store request accepted when high together with valid
- opstore_operation_done  out  1  one-cycle pulse, store complete
- sram_en  out  1  SRAM access strobe
- sram_we  out  1  SRAM write (qualified by sram_en)
- sram_addr  out  INDEX_W  SRAM word address
- sram_wdata  out  DATA_W  SRAM write data
- sram_wmask  out  DATA_W  SRAM bit write mask
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after a read strobe

## Operation
- FSM states: IDLE, BUSY, ACCESS, RESP. Reset state: IDLE.
- Transitions:
  - IDLE -> BUSY on acceptance; the counter loads LATENCY-1.
  - BUSY decrements the counter each cycle and goes to ACCESS when the counter is 0.
  - ACCESS -> RESP.
  - RESP -> IDLE.
- Arbitration:
  - Readies are high only in IDLE.
  - If exactly one channel is valid, that channel's ready is high.
  - If both channels are valid, grant the channel opposite to last_grant.
  - At most one ready is high per cycle.
  - Readies are combinational from state, both valids and last_grant. Upstream valid must not depend combinationally on ready.
- Acceptance (valid & ready at an edge) captures:
  - the operation type and the index;
  - for stores, write data and mask;
  - last_grant is updated to the granted channel.
- While not in IDLE, all channel inputs are ignored.
- ACCESS: drive sram_en=1, sram_we=1 for a store, sram_addr=captured index, sram_wdata/sram_wmask=captured values. In all other states sram_en=0 and sram_we=0.
- RESP: for a load, opload_read_data <= sram_rdata at the end of RESP. At the same edge, the matching done flop is set to 1 for exactly one cycle.
- Mask is passed bit-exact. A store with mask 0 still completes and still pulses done.
- Reset values:
  - both readies 0 while reset_n is low;
  - both done outputs 0, opload_read_data 0, sram_en 0, sram_we 0, sram_addr/wdata/wmask 0;
  - last_grant = store, so a load wins the first tie.
- Reset mid-operation: the in-flight request is dropped, with no done pulse and no further SRAM strobe. The FSM returns to IDLE after the reset edge.

## Timing
- Accept at edge E0. BUSY occupies cycles 1..LATENCY, ACCESS is cycle LATENCY+1, RESP is cycle LATENCY+2.
- Done is high in cycle LATENCY+3. Total latency from acceptance to done is LATENCY+3 cycles (5 at default).
- The FSM is IDLE in the done cycle, so ready can be high in that same cycle. Back-to-back throughput is one request per LATENCY+3 cycles.
- opload_read_data becomes valid in the done cycle and is stable until the next load done.
- The store done pulse does not change opload_read_data.
- Tie at IDLE with alternating persistent requests: grants alternate load, store, load, and so on.

## Test plan
- Reset, then hold both valids low for 10 cycles -> readies high only with valid, done 0, sram_en never 1, opload_read_data 0.
- Store index 0x00010, data 0x1122334455667788, mask all ones; then load index 0x00010 -> store done 5 cycles after acceptance; load done 5 cycles after its acceptance with opload_read_data 0x1122334455667788.
- Store data 0xFFFFFFFFFFFFFFFF with mask 0x00000000FFFFFFFF over the word above, then load the same index -> read data 0x11223344FFFFFFFF.
- Both valids high from reset, held continuously -> grant order load, store, load, store. Each grant is spaced 5 cycles apart, exactly one ready per grant cycle, and done pulses alternate channels.
- LATENCY=1 and LATENCY=15 builds, with a single load -> done at 4 and 18 cycles after acceptance; sram_en high exactly one cycle per request.
- Assert reset_n low during BUSY of a store, then release -> no store done, no sram_en/sram_we. A subsequent load of that index returns the pre-store contents.
